// File: rtl/axi_ic_pkg.sv
// Shared types and constants for the AXI interconnect write path.
package axi_ic_pkg;

    // Write-router transaction phases.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } wr_state_e;

    // B-channel response codes.
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // Addresses at or above this value belong to slave 2.
    localparam logic [31:0] S1_WINDOW = 32'h0000_0200;

endpackage

// File: rtl/wr_beat_counter.sv
// 8-bit saturating W-beat counter with synchronous clear and compare-to-length.
module wr_beat_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    input  logic [7:0] len,
    output logic [7:0] count,
    output logic       match
);

    logic [7:0] count_d;
    logic [7:0] count_q;

    // Next count: clear wins over increment; holds at 255 instead of wrapping.
    always_comb begin
        // NOTE: assign the default first so every path drives count_d and no latch is inferred.
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign match = (count_q == len);

endmodule

// File: rtl/axi_wr_router.sv
// Single-outstanding AXI write router: one master, two slaves, steered by an
// external combinational address decoder.
module axi_wr_router
    import axi_ic_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    // master AW
    input  logic [ADDR_W-1:0]   m_awaddr,
    input  logic [7:0]          m_awlen,
    input  logic                m_awvalid,
    output logic                m_awready,
    // master W
    input  logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_wlast,
    input  logic                m_wvalid,
    output logic                m_wready,
    // master B
    output logic [1:0]          m_bresp,
    output logic                m_bvalid,
    input  logic                m_bready,
    // address decoder
    output logic [ADDR_W-1:0]   dec_wr_addr,
    input  logic                dec_s1_sel,
    input  logic                dec_s2_sel,
    input  logic [ADDR_W-1:0]   dec_s1_addr,
    input  logic [ADDR_W-1:0]   dec_s2_addr,
    // slave 1
    output logic [ADDR_W-1:0]   s1_awaddr,
    output logic [7:0]          s1_awlen,
    output logic                s1_awvalid,
    input  logic                s1_awready,
    output logic [DATA_W-1:0]   s1_wdata,
    output logic [DATA_W/8-1:0] s1_wstrb,
    output logic                s1_wlast,
    output logic                s1_wvalid,
    input  logic                s1_wready,
    input  logic [1:0]          s1_bresp,
    input  logic                s1_bvalid,
    output logic                s1_bready,
    // slave 2
    output logic [ADDR_W-1:0]   s2_awaddr,
    output logic [7:0]          s2_awlen,
    output logic                s2_awvalid,
    input  logic                s2_awready,
    output logic [DATA_W-1:0]   s2_wdata,
    output logic [DATA_W/8-1:0] s2_wstrb,
    output logic                s2_wlast,
    output logic                s2_wvalid,
    input  logic                s2_wready,
    input  logic [1:0]          s2_bresp,
    input  logic                s2_bvalid,
    output logic                s2_bready
);

    wr_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         len_q, len_d;
    logic               sel_q, sel_d;           // 0: slave 1, 1: slave 2
    logic               latched_q, latched_d;   // decoder result captured
    logic               awvalid_q, awvalid_d;   // AW being offered to the slave
    logic [ADDR_W-1:0]  s1_awaddr_q, s1_awaddr_d;
    logic [ADDR_W-1:0]  s2_awaddr_q, s2_awaddr_d;
    logic               mismatch_q, mismatch_d;
    logic               awready_q, awready_d;

    logic               in_addr, in_data, in_resp;
    logic               aw_hs, w_hs, b_hs;
    logic               sel_awready, sel_wready, sel_bvalid;
    logic [1:0]         sel_bresp;
    logic [7:0]         beat_cnt;
    logic               cnt_match;

    assign in_addr = (state_q == ADDR);
    assign in_data = (state_q == DATA);
    assign in_resp = (state_q == RESP);

    assign sel_awready = sel_q ? s2_awready : s1_awready;
    assign sel_wready  = sel_q ? s2_wready  : s1_wready;
    assign sel_bvalid  = sel_q ? s2_bvalid  : s1_bvalid;
    assign sel_bresp   = sel_q ? s2_bresp   : s1_bresp;

    assign aw_hs = (state_q == IDLE) && m_awvalid && awready_q;
    assign w_hs  = in_data && m_wvalid && sel_wready;
    assign b_hs  = in_resp && sel_bvalid && m_bready;

    wr_beat_counter u_beat_cnt (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .clr   (aw_hs),
        .inc   (w_hs),
        .len   (len_q),
        .count (beat_cnt),
        .match (cnt_match)
    );

    // Next-state and captured-field logic for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        sel_d       = sel_q;
        latched_d   = latched_q;
        awvalid_d   = awvalid_q;
        s1_awaddr_d = s1_awaddr_q;
        s2_awaddr_d = s2_awaddr_q;
        mismatch_d  = mismatch_q;

        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    addr_d    = m_awaddr;
                    len_d     = m_awlen;
                    latched_d = 1'b0;
                    awvalid_d = 1'b0;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (!latched_q) begin
                    // Decoder has had a full cycle on addr_q; slave 1 wins if both selects are ever set.
                    sel_d     = dec_s2_sel && !dec_s1_sel;
                    latched_d = 1'b1;
                    if (dec_s2_sel && !dec_s1_sel) begin
                        s2_awaddr_d = dec_s2_addr;
                    end else begin
                        s1_awaddr_d = dec_s1_addr;
                    end
                end else if (!awvalid_q) begin
                    awvalid_d = 1'b1;
                end else if (sel_awready) begin
                    awvalid_d = 1'b0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (w_hs && m_wlast) begin
                    mismatch_d = !cnt_match;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (b_hs) begin
                    mismatch_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        awready_d = (state_d == IDLE);
    end

    // State and captured-field registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            sel_q       <= 1'b0;
            latched_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            s1_awaddr_q <= '0;
            s2_awaddr_q <= '0;
            mismatch_q  <= 1'b0;
            awready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            sel_q       <= sel_d;
            latched_q   <= latched_d;
            awvalid_q   <= awvalid_d;
            s1_awaddr_q <= s1_awaddr_d;
            s2_awaddr_q <= s2_awaddr_d;
            mismatch_q  <= mismatch_d;
            awready_q   <= awready_d;
        end
    end

    // Channel outputs: AW from registers, W and B as zero-latency steering.
    always_comb begin
        dec_wr_addr = addr_q;
        m_awready   = awready_q;

        s1_awaddr   = s1_awaddr_q;
        s2_awaddr   = s2_awaddr_q;
        s1_awlen    = len_q;
        s2_awlen    = len_q;
        s1_awvalid  = in_addr && awvalid_q && !sel_q;
        s2_awvalid  = in_addr && awvalid_q && sel_q;

        m_wready    = in_data && sel_wready;
        s1_wvalid   = in_data && m_wvalid && !sel_q;
        s2_wvalid   = in_data && m_wvalid && sel_q;
        s1_wdata    = (in_data && !sel_q) ? m_wdata : '0;
        s1_wstrb    = (in_data && !sel_q) ? m_wstrb : '0;
        s1_wlast    = in_data && !sel_q && m_wlast;
        s2_wdata    = (in_data && sel_q) ? m_wdata : '0;
        s2_wstrb    = (in_data && sel_q) ? m_wstrb : '0;
        s2_wlast    = in_data && sel_q && m_wlast;

        m_bvalid    = in_resp && sel_bvalid;
        m_bresp     = !in_resp ? OKAY : (mismatch_q ? SLVERR : sel_bresp);
        s1_bready   = in_resp && !sel_q && m_bready;
        s2_bready   = in_resp && sel_q && m_bready;
    end

    // Once saturated inside a burst, the beat count must stay at 255.
    a_cnt_saturates: assert property (@(posedge ACLK) disable iff (!ARESETn)
        (in_data && beat_cnt == 8'hFF) |=> (beat_cnt == 8'hFF));

endmodule

// File: tb/tb_axi_wr_router.sv
// Scoreboard bench for axi_wr_router with a behavioural address decoder.
module tb_axi_wr_router;
    import axi_ic_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          ACLK, ARESETn;
    logic [AW-1:0] m_awaddr;
    logic [7:0]    m_awlen;
    logic          m_awvalid, m_awready;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    logic          m_wlast, m_wvalid, m_wready;
    logic [1:0]    m_bresp;
    logic          m_bvalid, m_bready;
    logic [AW-1:0] dec_wr_addr, dec_s1_addr, dec_s2_addr;
    logic          dec_s1_sel, dec_s2_sel;
    logic [AW-1:0] s1_awaddr, s2_awaddr;
    logic [7:0]    s1_awlen, s2_awlen;
    logic          s1_awvalid, s1_awready, s2_awvalid, s2_awready;
    logic [DW-1:0] s1_wdata, s2_wdata;
    logic [SW-1:0] s1_wstrb, s2_wstrb;
    logic          s1_wlast, s1_wvalid, s1_wready, s2_wlast, s2_wvalid, s2_wready;
    logic [1:0]    s1_bresp, s2_bresp;
    logic          s1_bvalid, s1_bready, s2_bvalid, s2_bready;

    axi_wr_router #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .dec_wr_addr(dec_wr_addr), .dec_s1_sel(dec_s1_sel), .dec_s2_sel(dec_s2_sel),
        .dec_s1_addr(dec_s1_addr), .dec_s2_addr(dec_s2_addr),
        .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
        .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
        .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
        .s2_awaddr(s2_awaddr), .s2_awlen(s2_awlen), .s2_awvalid(s2_awvalid), .s2_awready(s2_awready),
        .s2_wdata(s2_wdata), .s2_wstrb(s2_wstrb), .s2_wlast(s2_wlast), .s2_wvalid(s2_wvalid), .s2_wready(s2_wready),
        .s2_bresp(s2_bresp), .s2_bvalid(s2_bvalid), .s2_bready(s2_bready)
    );

    // Interconnect decoder: two windows split at S1_WINDOW.
    assign dec_s2_sel  = (dec_wr_addr >= S1_WINDOW);
    assign dec_s1_sel  = !dec_s2_sel;
    assign dec_s1_addr = dec_wr_addr;
    assign dec_s2_addr = dec_wr_addr - S1_WINDOW;

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    typedef struct { int slv; logic [31:0] addr; logic [7:0] len; } aw_exp_t;
    typedef struct { int slv; logic [31:0] data; logic [3:0] strb; logic last; } w_exp_t;

    aw_exp_t     aw_q[$];
    w_exp_t      w_q[$];
    logic [1:0]  b_q[$];

    int cyc = 0;
    int cap_cyc = 0;
    bit aw_seen = 1'b1;
    bit exp_fast = 1'b0;
    int cur_slave = 1;
    bit toggle_en = 1'b0;

    always @(posedge ACLK) cyc <= cyc + 1;

    // s1_wready follows a toggle pattern when enabled, otherwise stays high.
    initial begin
        s1_wready = 1'b1;
        forever begin
            @(posedge ACLK);
            #1;
            s1_wready = toggle_en ? ~s1_wready : 1'b1;
        end
    end

    task automatic pop_aw(input int slv);
        aw_exp_t e;
        if (aw_q.size() == 0) begin
            check("aw_unexpected", 1, 0);
        end else begin
            e = aw_q.pop_front();
            check("aw_slave", slv, e.slv);
            check("aw_addr", (slv == 1) ? s1_awaddr : s2_awaddr, e.addr);
            check("aw_len", (slv == 1) ? s1_awlen : s2_awlen, e.len);
        end
    endtask

    task automatic pop_w(input int slv);
        w_exp_t e;
        if (w_q.size() == 0) begin
            check("w_unexpected", 1, 0);
        end else begin
            e = w_q.pop_front();
            check("w_slave", slv, e.slv);
            check("w_data", (slv == 1) ? s1_wdata : s2_wdata, e.data);
            check("w_strb", (slv == 1) ? s1_wstrb : s2_wstrb, e.strb);
            check("w_last", (slv == 1) ? s1_wlast : s2_wlast, e.last);
        end
    endtask

    // Output monitor: sampled mid-cycle, compares each handshake with the scoreboard.
    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (m_awvalid && m_awready) begin
                cap_cyc = cyc + 1;
                aw_seen = 1'b0;
            end
            if ((s1_awvalid || s2_awvalid) && !aw_seen) begin
                aw_seen = 1'b1;
                check("aw_latency", cyc - cap_cyc, 2);
            end
            if (s1_awvalid && s1_awready) pop_aw(1);
            if (s2_awvalid && s2_awready) pop_aw(2);
            if (s1_wvalid && s1_wready) pop_w(1);
            if (s2_wvalid && s2_wready) pop_w(2);
            if (m_bvalid && m_bready) begin
                if (b_q.size() == 0) begin
                    check("b_unexpected", 1, 0);
                end else begin
                    check("b_resp", m_bresp, b_q.pop_front());
                    if (exp_fast) check("txn_cycles", cyc + 1 - cap_cyc, 5);
                end
            end
            if (cur_slave == 1 && (s2_awvalid || s2_wvalid || s2_bready)) check("s2_quiet", 1, 0);
            if (cur_slave == 2 && (s1_awvalid || s1_wvalid || s1_bready)) check("s1_quiet", 1, 0);
        end
    end

    task automatic reset_pulse_checks();
        #3;
        ARESETn = 1'b0;
        #1;
        check("rst_m_awready", m_awready, 0);
        check("rst_m_wready", m_wready, 0);
        check("rst_m_bvalid", m_bvalid, 0);
        check("rst_s1_awvalid", s1_awvalid, 0);
        check("rst_s2_awvalid", s2_awvalid, 0);
        check("rst_s1_wvalid", s1_wvalid, 0);
        check("rst_s2_wvalid", s2_wvalid, 0);
        check("rst_s1_bready", s1_bready, 0);
        check("rst_s1_wdata", s1_wdata, 0);
        check("rst_s1_awaddr", s1_awaddr, 0);
        m_wvalid  = 1'b0;
        m_wlast   = 1'b0;
        toggle_en = 1'b0;
        exp_fast  = 1'b0;
        w_q.delete();
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        check("awready_before_edge", m_awready, 0);
        @(posedge ACLK);
        #1;
        check("awready_after_edge", m_awready, 1);
    endtask

    // Drives one write; abort_at >= 0 pulses reset before presenting that beat.
    task automatic write_txn(input logic [31:0] addr, input logic [7:0] len, input int nbeats,
                             input bit toggle, input int bready_delay, input logic [1:0] slv_resp,
                             input bit fast, input int abort_at);
        int         slv;
        int         t;
        w_exp_t     w;
        logic [1:0] exp_resp;
        slv       = (addr >= S1_WINDOW) ? 2 : 1;
        cur_slave = slv;
        exp_fast  = fast;
        aw_q.push_back('{slv, (slv == 2) ? addr - S1_WINDOW : addr, len});

        m_awaddr  = addr;
        m_awlen   = len;
        m_awvalid = 1'b1;
        @(negedge ACLK);
        t = 0;
        while (!m_awready && t < 50) begin @(negedge ACLK); t++; end
        if (t == 50) check("aw_timeout", 1, 0);
        @(posedge ACLK);
        #1;
        m_awvalid = 1'b0;
        toggle_en = toggle;

        for (int i = 0; i < nbeats; i++) begin
            if (i == abort_at) begin
                reset_pulse_checks();
                return;
            end
            w.slv  = slv;
            w.data = $urandom;
            w.strb = 4'($urandom_range(0, 15));
            w.last = (i == nbeats - 1);
            w_q.push_back(w);
            m_wdata  = w.data;
            m_wstrb  = w.strb;
            m_wlast  = w.last;
            m_wvalid = 1'b1;
            @(negedge ACLK);
            t = 0;
            while (!m_wready && t < 50) begin @(negedge ACLK); t++; end
            if (t == 50) check("w_timeout", 1, 0);
            @(posedge ACLK);
            #1;
        end
        m_wvalid  = 1'b0;
        m_wlast   = 1'b0;
        toggle_en = 1'b0;

        exp_resp = (nbeats - 1 != int'(len)) ? SLVERR : slv_resp;
        b_q.push_back(exp_resp);
        if (slv == 1) begin s1_bvalid = 1'b1; s1_bresp = slv_resp; end
        else          begin s2_bvalid = 1'b1; s2_bresp = slv_resp; end

        for (int k = 0; k < bready_delay; k++) begin
            m_bready = 1'b0;
            @(negedge ACLK);
            check("b_hold_valid", m_bvalid, 1);
            check("b_hold_resp", m_bresp, exp_resp);
            @(posedge ACLK);
            #1;
        end
        m_bready = 1'b1;
        @(negedge ACLK);
        t = 0;
        while (!m_bvalid && t < 50) begin @(negedge ACLK); t++; end
        if (t == 50) check("b_timeout", 1, 0);
        @(posedge ACLK);
        #1;
        s1_bvalid = 1'b0;
        s2_bvalid = 1'b0;
        m_bready  = 1'b0;
        @(negedge ACLK);
        check("awready_back", m_awready, 1);
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        ARESETn   = 1'b0;
        m_awaddr  = '0; m_awlen = '0; m_awvalid = 1'b0;
        m_wdata   = '0; m_wstrb = '0; m_wlast = 1'b0; m_wvalid = 1'b0;
        m_bready  = 1'b0;
        s1_awready = 1'b1; s2_awready = 1'b1; s2_wready = 1'b1;
        s1_bresp  = OKAY; s1_bvalid = 1'b0;
        s2_bresp  = OKAY; s2_bvalid = 1'b0;

        repeat (2) @(posedge ACLK);
        #2;
        check("reset_m_awready", m_awready, 0);
        check("reset_s1_awvalid", s1_awvalid, 0);
        check("reset_m_wready", m_wready, 0);
        check("reset_m_bvalid", m_bvalid, 0);
        check("reset_s1_awaddr", s1_awaddr, 0);
        check("reset_s2_awlen", s2_awlen, 0);
        check("reset_dec_addr", dec_wr_addr, 0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        check("awready_pre_edge", m_awready, 0);
        @(posedge ACLK);
        #1;
        check("awready_first_edge", m_awready, 1);

        write_txn(32'h0000_0100, 8'd3, 4, 1'b0, 0, OKAY,   1'b0, -1);
        write_txn(32'h0000_0204, 8'd0, 1, 1'b0, 0, OKAY,   1'b1, -1);
        write_txn(32'h0000_01FC, 8'd0, 1, 1'b0, 0, OKAY,   1'b1, -1);
        write_txn(32'h0000_0200, 8'd0, 1, 1'b0, 0, OKAY,   1'b1, -1);
        write_txn(32'h0000_0080, 8'd5, 6, 1'b1, 3, 2'b01,  1'b0, -1);
        write_txn(32'h0000_0300, 8'd3, 2, 1'b0, 0, OKAY,   1'b0, -1);
        write_txn(32'h0000_0040, 8'd1, 3, 1'b0, 0, OKAY,   1'b0, -1);
        write_txn(32'h0000_0020, 8'd0, 1, 1'b0, 0, SLVERR, 1'b0, -1);
        write_txn(32'h0000_0150, 8'd3, 4, 1'b0, 0, OKAY,   1'b0, 2);
        write_txn(32'h0000_0010, 8'd1, 2, 1'b0, 0, OKAY,   1'b0, -1);

        check("aw_q_drained", aw_q.size(), 0);
        check("w_q_drained", w_q.size(), 0);
        check("b_q_drained", b_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_wr_router.md
# axi_wr_router

Write-channel router between one AXI master and two AXI slaves. Accepts a write address, presents it to the interconnect address decoder, and forwards AW to the selected slave using the decoder's slave-relative address. It then steers W beats to that slave until WLAST and returns the slave's B response to the master. One transaction is in flight at a time; it sits directly downstream of the address decoder on the write path.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- ACLK  in  1  clock, all state on rising edge
- ARESETn  in  1  asynchronous, active-low reset
- m_awaddr  in  ADDR_W  master write address
- m_awlen  in  8  beats minus one
- m_awvalid / m_awready  in / out  1  master AW handshake
- m_wdata, m_wstrb, m_wlast, m_wvalid  in  DATA_W, DATA_W/8, 1, 1  master W channel
- m_wready  out  1
- m_bresp, m_bvalid  out  2, 1  master B channel
- m_bready  in  1
- dec_wr_addr  out  ADDR_W  captured address to decoder (wr_addr)
- dec_s1_sel, dec_s2_sel  in  1  decoder write selects
- dec_s1_addr, dec_s2_addr  in  ADDR_W  decoder slave-relative addresses
- sN_awaddr, sN_awlen, sN_awvalid  out  ADDR_W, 8, 1  per slave (N=1,2)
- sN_awready  in  1
- sN_wdata, sN_wstrb, sN_wlast, sN_wvalid  out  per slave
- sN_wready  in  1
- sN_bresp, sN_bvalid  in  2, 1
- sN_bready  out  1

## Operation
- States: IDLE, ADDR, DATA, RESP.
- IDLE: m_awready=1. On m_awvalid&m_awready, capture awaddr into addr_q and awlen into len_q, clear beat counter, go to ADDR.
- dec_wr_addr = addr_q. The decoder is combinational. In ADDR, register sel_q=dec_s2_sel on entry-cycle+1 and latch the matching dec_sN_addr into sN_awaddr.
- ADDR: assert only the selected sN_awvalid. sN_awlen=len_q. On sN_awready, go to DATA.
- DATA: zero-latency pass-through to the selected slave only.
  - sN_wvalid = m_wvalid & sel.
  - m_wready = selected sN_wready.
  - wdata, wstrb and wlast are copied.
  - The unselected slave sees wvalid=0.
  - Each accepted beat increments an 8-bit counter.
  - An accepted beat with m_wlast goes to RESP. Set mismatch_q if the counter is not equal to len_q on that beat.
- RESP: m_bvalid = selected sN_bvalid; sN_bready = m_bready for the selected slave only.
  - m_bresp = sN_bresp, overridden to 2'b10 (SLVERR) when mismatch_q=1.
  - On m_bvalid&m_bready, go to IDLE and clear mismatch_q.
- Beats beyond len_q without wlast are forwarded unchanged; the counter saturates at 255.
- Outside the listed states, every valid/ready output is 0.

## Timing
- Reset (async assert): state=IDLE, m_awready=0, all sN_*valid=0, m_wready=0, m_bvalid=0, sN_bready=0, addr_q=0, len_q=0, counter=0, mismatch_q=0. sN_awaddr/awlen/w* data outputs are 0.
- m_awready is registered: it rises on the first ACLK edge after ARESETn deasserts.
  - It falls on the capture edge and rises on the edge that returns to IDLE.
- AW capture at edge N. sN_awvalid is high after edge N+2, allowing one cycle for decoder settle and latch.
- sN_awvalid holds until sN_awready; the address is stable while valid.
- W and B paths are combinational: 0-cycle latency, one beat per cycle at full throughput.
- Minimum transaction for 1 beat with all readies high: capture, settle, AW, W, B gives 5 cycles back to IDLE.
- Reset asserted mid-transaction: all valids drop immediately, FSM is in IDLE, and the in-flight transaction is abandoned.

## Structure
- Shared package axi_ic_pkg holds:
  - the state enum (IDLE, ADDR, DATA, RESP);
  - BRESP constants OKAY=2'b00 and SLVERR=2'b10;
  - the slave-1 window constant 32'h0000_0200.
- One sub-module: wr_beat_counter. It is an 8-bit saturating counter with clear, increment and compare-to-len. Its outputs are count and match.

## Test plan
- Write to 0x0000_0100, awlen=3, 4 beats, all readies high: s1 gets awaddr 0x100, awlen 3, 4 beats. Master gets bresp 00. s2 sees no valid.
- Write to 0x0000_0204, awlen=0: s2_awaddr=0x0000_0004, one beat to s2, B forwarded.
- Boundary 0x0000_01FC → s1 and 0x0000_0200 → s2 with s2_awaddr=0.
- Backpressure: s1_wready toggles every cycle, m_bready held low 3 cycles. No beat is lost or duplicated, and B is held stable until m_bready.
- Length mismatch: awlen=3, wlast on beat 2. The transaction completes and m_bresp=2'b10 even though the slave returned 00.
- ARESETn pulsed low during DATA: all valids are 0 asynchronously. After release, m_awready=1 one edge later, and a new write to 0x0000_0010 completes normally.
